// File: rtl/shake256_stream_ctrl.sv
// Streaming sequencer for one SHAKE256 core: packs 64-bit words into 1088-bit rate blocks,
// double-buffers them toward the core and returns a programmed number of squeezed blocks.
module shake256_stream_ctrl #(
    parameter int LEN_W    = 16,
    parameter int OUTCNT_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [LEN_W-1:0]    msg_bits,
    input  logic [OUTCNT_W-1:0] out_blocks,
    input  logic [63:0]         in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [1087:0]       out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                underrun,
    output logic                overrun,
    output logic                core_rst_n,
    output logic [1087:0]       core_message,
    output logic [10:0]         core_length,
    input  logic                core_busy,
    input  logic                core_full,
    input  logic                core_squeezed,
    input  logic [1087:0]       core_hash,
    output logic [2:0]          state_dbg
);

    // Handshakes: a word moves on in_valid & in_ready, a block on out_valid & out_ready;
    // out_valid/out_data hold until accepted, in_ready never depends on in_valid.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL0   = 3'd1,
        LAUNCH  = 3'd2,
        ABSORB  = 3'd3,
        SQUEEZE = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    localparam int                WCNT_W    = LEN_W - 5;
    localparam logic [LEN_W-1:0]  RATE_BITS = LEN_W'(1088);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(2047);
    localparam logic [63:0]       ONES      = 64'hFFFF_FFFF_FFFF_FFFF;

    state_t              state, state_nx;
    logic [LEN_W-1:0]    rem;
    logic [LEN_W-1:0]    rem_next;
    logic [WCNT_W-1:0]   words_left;
    logic [5:0]          tail_bits;
    logic [4:0]          fill_cnt;
    logic [OUTCNT_W-1:0] out_target;
    logic [OUTCNT_W-1:0] sq_cnt;
    logic [1087:0]       shadow;
    logic [10:0]         wr_lsb;
    logic [63:0]         word_in;
    logic                shadow_done;
    logic                more_blk;
    logic                word_take;
    logic                hash_load;
    logic                sq_last;
    logic                unused_core_busy;

    // core_busy is informational only; sequencing keys off the core_full/core_squeezed pulses.
    assign unused_core_busy = core_busy;

    function automatic logic [10:0] sat_len(input logic [LEN_W-1:0] v);
        return (v > LEN_MAX) ? 11'd2047 : v[10:0];
    endfunction

    assign shadow_done = (fill_cnt == 5'd17) || (words_left == '0);
    assign more_blk    = rem > RATE_BITS;
    assign rem_next    = more_blk ? (rem - RATE_BITS) : '0;
    assign word_take   = in_valid && in_ready;
    assign hash_load   = (state == SQUEEZE) && core_squeezed && (!out_valid || out_ready);
    assign sq_last     = (sq_cnt == (out_target - OUTCNT_W'(1)));
    assign wr_lsb      = 11'(5'd16 - fill_cnt) << 6;
    // The final partial word keeps only its top tail_bits; the rest of the block stays zero.
    assign word_in     = ((words_left == WCNT_W'(1)) && (tail_bits != 6'd0))
                         ? (in_data & ~(ONES >> tail_bits)) : in_data;

    assign busy       = (state != IDLE);
    assign core_rst_n = (state == LAUNCH) || (state == ABSORB) || (state == SQUEEZE);
    assign state_dbg  = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = FILL0;
            end
            FILL0: begin
                in_ready = !shadow_done;
                if (shadow_done) state_nx = LAUNCH;
            end
            LAUNCH: begin
                state_nx = ABSORB;
            end
            ABSORB: begin
                in_ready = !shadow_done && more_blk;
                if (core_full) begin
                    if (!more_blk) state_nx = SQUEEZE;
                    else if (!shadow_done) state_nx = IDLE;
                end
            end
            SQUEEZE: begin
                if (core_squeezed && sq_last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (out_valid && out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem          <= '0;
            words_left   <= '0;
            tail_bits    <= '0;
            fill_cnt     <= '0;
            out_target   <= '0;
            sq_cnt       <= '0;
            shadow       <= '0;
            core_message <= '0;
            core_length  <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            done <= (state == DRAIN) && out_valid && out_ready;

            if ((state == IDLE) && start) begin
                rem        <= msg_bits;
                words_left <= {1'b0, msg_bits[LEN_W-1:6]} + WCNT_W'(msg_bits[5:0] != 6'd0);
                tail_bits  <= msg_bits[5:0];
                out_target <= (out_blocks == '0) ? OUTCNT_W'(1) : out_blocks;
                sq_cnt     <= '0;
                shadow     <= '0;
                fill_cnt   <= '0;
                underrun   <= 1'b0;
                overrun    <= 1'b0;
            end

            if (word_take) begin
                shadow[wr_lsb +: 64] <= word_in;
                fill_cnt             <= fill_cnt + 5'd1;
                words_left           <= words_left - WCNT_W'(1);
            end

            if ((state == FILL0) && shadow_done) begin
                core_message <= shadow;
                core_length  <= sat_len(rem);
                shadow       <= '0;
                fill_cnt     <= '0;
            end

            // The swap lands on the edge closing the core_full cycle, so the core sees the
            // next block on the following cycle as it expects.
            if ((state == ABSORB) && core_full) begin
                rem <= rem_next;
                if (more_blk) begin
                    if (shadow_done) begin
                        core_message <= shadow;
                        core_length  <= sat_len(rem_next);
                        shadow       <= '0;
                        fill_cnt     <= '0;
                    end else begin
                        underrun <= 1'b1;
                    end
                end
            end

            if (hash_load) begin
                out_data  <= core_hash;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if ((state == SQUEEZE) && core_squeezed) begin
                sq_cnt <= sq_cnt + OUTCNT_W'(1);
                if (!hash_load) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shake256_stream_ctrl.sv
// Directed bench for shake256_stream_ctrl: the bench plays DMA, core and consumer, with
// hand-computed expectations checked by immediate assertions.
module tb_shake256_stream_ctrl;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   msg_bits = '0;
    logic [3:0]    out_blocks = '0;
    logic [63:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1087:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          underrun;
    logic          overrun;
    logic          core_rst_n;
    logic [1087:0] core_message;
    logic [10:0]   core_length;
    logic          core_busy = 1'b0;
    logic          core_full = 1'b0;
    logic          core_squeezed = 1'b0;
    logic [1087:0] core_hash = '0;
    logic [2:0]    state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    logic [1087:0] exp_q[$];

    shake256_stream_ctrl #(.LEN_W(16), .OUTCNT_W(4)) dut (
        .clock(clock), .reset(reset), .start(start), .msg_bits(msg_bits),
        .out_blocks(out_blocks), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .underrun(underrun),
        .overrun(overrun), .core_rst_n(core_rst_n), .core_message(core_message),
        .core_length(core_length), .core_busy(core_busy), .core_full(core_full),
        .core_squeezed(core_squeezed), .core_hash(core_hash), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (reset && in_valid && in_ready === 1'b1) acc_cnt <= acc_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, expected finish before 200000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [1087:0] obs, input logic [1087:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h..%h expected %h..%h", tag,
                   obs[1087:1024], obs[63:0], exp[1087:1024], exp[63:0]);
        end
    endtask

    function automatic logic [63:0] wd(input int i);
        return {56'ha3a3_a3a3_a3a3_a3, 8'(i)};
    endfunction

    function automatic logic [1087:0] hv(input int k);
        return {17{64'hc0de_5a5a_0000_0000 | 64'(k)}};
    endfunction

    // Called on a falling edge; returns on the falling edge after the word was taken.
    task automatic send_word(input logic [63:0] d);
        int t;
        t = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        chk("in_ready_wait", in_ready, 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_full();
        core_full = 1'b1;
        @(negedge clock);
        core_full = 1'b0;
    endtask

    task automatic squeeze(input logic [1087:0] h);
        core_hash     = h;
        core_squeezed = 1'b1;
        @(negedge clock);
        core_squeezed = 1'b0;
    endtask

    // 1600-bit message, four output blocks; optionally a second start is pulsed mid-fill.
    task automatic run_basic(input bit inject);
        logic [1087:0] b0, b1;
        int d0, a0;
        b0 = '0;
        b1 = '0;
        for (int i = 0; i < 17; i++) b0[1087-64*i -: 64] = wd(i);
        for (int i = 0; i < 8; i++)  b1[1087-64*i -: 64] = wd(17 + i);
        d0 = done_cnt;
        a0 = acc_cnt;
        out_ready  = 1'b1;
        core_busy  = 1'b1;
        start      = 1'b1;
        msg_bits   = 16'd1600;
        out_blocks = 4'd4;
        @(negedge clock);
        start = 1'b0;
        chk("b_busy", busy, 64'd1);
        for (int i = 0; i < 17; i++) begin
            if (inject && i == 5) begin
                start      = 1'b1;
                msg_bits   = 16'd64;
                out_blocks = 4'd1;
            end
            send_word(wd(i));
            start = 1'b0;
        end
        chk("b_fill0_ready_low", in_ready, 64'd0);
        @(negedge clock);
        chk("b_launch_rst_n", core_rst_n, 64'd1);
        chk_w("b_block0", core_message, b0);
        chk("b_len0", core_length, 64'd1600);
        for (int i = 0; i < 8; i++) send_word(wd(17 + i));
        chk("b_shadow_ready_low", in_ready, 64'd0);
        chk_w("b_block0_held", core_message, b0);
        pulse_full();
        chk_w("b_block1", core_message, b1);
        chk("b_len1", core_length, 64'd512);
        chk("b_no_underrun", underrun, 64'd0);
        idle(2);
        pulse_full();
        core_busy = 1'b0;
        chk("b_squeeze_busy", busy, 64'd1);
        chk("b_squeeze_ready", in_ready, 64'd0);
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(hv(k));
            squeeze(hv(k));
            chk("b_out_valid", out_valid, 64'd1);
            chk_w("b_out_data", out_data, exp_q.pop_front());
            chk("b_sq_core_rst", core_rst_n, 64'(k < 4));
            if (k < 4) idle(1);
        end
        @(negedge clock);
        chk("b_done", done, 64'd1);
        chk("b_idle", busy, 64'd0);
        @(negedge clock);
        chk("b_done_pulse", done, 64'd0);
        chk("b_done_count", 64'(done_cnt - d0), 64'd1);
        chk("b_words_taken", 64'(acc_cnt - a0), 64'd25);
        chk("b_flag_underrun", underrun, 64'd0);
        chk("b_flag_overrun", overrun, 64'd0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_in_ready", in_ready, 64'd0);
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_core_rst_n", core_rst_n, 64'd0);
        chk("rst_state", state_dbg, 64'd0);
        chk_w("rst_core_message", core_message, '0);
        reset = 1'b1;
        @(negedge clock);

        // Full two-block message
        run_basic(1'b0);

        // Empty message, out_blocks 0 means one block
        start      = 1'b1;
        msg_bits   = 16'd0;
        out_blocks = 4'd0;
        @(negedge clock);
        start = 1'b0;
        chk("e_ready_low", in_ready, 64'd0);
        @(negedge clock);
        chk_w("e_message", core_message, '0);
        chk("e_len", core_length, 64'd0);
        chk("e_rst_n", core_rst_n, 64'd1);
        @(negedge clock);
        chk("e_absorb_ready", in_ready, 64'd0);
        pulse_full();
        squeeze(hv(7));
        chk("e_out_valid", out_valid, 64'd1);
        chk_w("e_out_data", out_data, hv(7));
        @(negedge clock);
        chk("e_done", done, 64'd1);
        chk("e_idle", busy, 64'd0);

        // Two full blocks with a stall in block 1: underrun abort
        start      = 1'b1;
        msg_bits   = 16'd2176;
        out_blocks = 4'd1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 17; i++) send_word(wd(i));
        @(negedge clock);
        chk("u_len_sat", core_length, 64'd2047);
        for (int i = 0; i < 5; i++) send_word(wd(17 + i));
        idle(10);
        pulse_full();
        chk("u_underrun", underrun, 64'd1);
        chk("u_busy", busy, 64'd0);
        chk("u_core_rst_n", core_rst_n, 64'd0);
        chk("u_in_ready", in_ready, 64'd0);
        idle(30);
        chk("u_sticky", underrun, 64'd1);

        // Partial last word, consumer stalled: overrun on later squeezes
        out_ready  = 1'b0;
        start      = 1'b1;
        msg_bits   = 16'd100;
        out_blocks = 4'd3;
        @(negedge clock);
        start = 1'b0;
        chk("o_underrun_cleared", underrun, 64'd0);
        send_word(64'h0123_4567_89ab_cdef);
        send_word(64'hffff_ffff_ffff_ffff);
        @(negedge clock);
        chk_w("o_message", core_message,
              {64'h0123_4567_89ab_cdef, 64'hffff_ffff_f000_0000, 960'd0});
        chk("o_len", core_length, 64'd100);
        @(negedge clock);
        pulse_full();
        squeeze(hv(1));
        chk("o_valid1", out_valid, 64'd1);
        chk("o_no_overrun", overrun, 64'd0);
        idle(1);
        squeeze(hv(2));
        chk("o_overrun", overrun, 64'd1);
        chk_w("o_held", out_data, hv(1));
        idle(1);
        squeeze(hv(3));
        chk("o_drain_rst_n", core_rst_n, 64'd0);
        chk_w("o_held2", out_data, hv(1));
        idle(3);
        chk("o_no_done", done, 64'd0);
        chk("o_valid_held", out_valid, 64'd1);
        out_ready = 1'b1;
        @(negedge clock);
        chk("o_done", done, 64'd1);
        chk("o_valid_clear", out_valid, 64'd0);
        chk("o_overrun_sticky", overrun, 64'd1);

        // Asynchronous reset in the middle of ABSORB
        start      = 1'b1;
        msg_bits   = 16'd1600;
        out_blocks = 4'd4;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 17; i++) send_word(wd(i));
        idle(2);
        for (int i = 0; i < 3; i++) send_word(wd(17 + i));
        #2 reset = 1'b0;
        #1;
        chk("a_in_ready", in_ready, 64'd0);
        chk("a_out_valid", out_valid, 64'd0);
        chk("a_busy", busy, 64'd0);
        chk("a_done", done, 64'd0);
        chk("a_flags", {underrun, overrun}, 64'd0);
        chk("a_core_rst_n", core_rst_n, 64'd0);
        chk("a_core_length", core_length, 64'd0);
        chk_w("a_core_message", core_message, '0);
        chk_w("a_out_data", out_data, '0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_basic(1'b0);

        // Start pulsed while busy is ignored
        run_basic(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
